lsu_mem_stage: RTL
==================

Name: lsu_mem_stage

Overview:
- Load/store unit directly downstream of the integer ALU.
- Takes the ALU result as the effective address, plus rs2 store data and funct3 from decode.
- Performs one word-bus transaction per request: lane steering, byte enables, load extraction and sign/zero extension.
- Returns the load result (or a fault) to writeback. Multi-cycle; the pipeline stalls on O_ready low.

Parameters:
- TIMEOUT_CYCLES, 16, cycles in WAIT without I_mem_ack before a bus-timeout fault; range 1..255.

Ports:
- I_clk  input  1  system clock, rising edge
- I_rst_n  input  1  asynchronous active-low reset
- I_valid  input  1  request strobe; accepted only when O_ready=1
- I_load  input  1  request is a load
- I_store  input  1  request is a store
- I_funct3  input  3  RISC-V funct3 (size/signedness)
- I_addr  input  32  effective address (ALU O_data)
- I_wdata  input  32  store data (rs2)
- O_ready  output  1  unit idle, may accept a request
- O_done  output  1  one-cycle pulse: request completed without fault
- O_rdata  output  32  extended load result; 0 after a store
- O_fault  output  1  one-cycle pulse: request aborted
- O_fault_cause  output  2  01 misaligned, 10 bus timeout, 11 illegal op; held until next fault
- O_mem_req  output  1  bus request, held until ack
- O_mem_we  output  1  1=write
- O_mem_addr  output  32  word-aligned address {addr[31:2],2'b00}
- O_mem_wdata  output  32  lane-replicated store data
- O_mem_be  output  4  byte enables (1111 for loads)
- I_mem_ack  input  1  bus completion, one cycle
- I_mem_rdata  input  32  read word, valid with I_mem_ack

Behaviour:
- Reset (async, I_rst_n=0): state=IDLE, timeout counter=0, all outputs 0 except O_ready=1.
- Reset mid-transaction abandons the transaction: O_mem_req drops immediately, no done/fault.
- States: IDLE, WAIT, RESP.
- IDLE, O_ready=1:
  - I_valid=1 latches all request inputs and validates them.
  - Illegal (cause 11): I_load=I_store, load funct3 in {011,110,111}, store funct3 not in {000,001,010}.
  - Misaligned (cause 01): halfword with addr[0]=1, word with addr[1:0]!=00. Illegal is checked before misaligned.
  - Fault → next cycle O_fault=1, O_ready=1, no bus activity; stay IDLE.
  - Otherwise → WAIT; O_ready=0 from the next cycle.
- WAIT: O_mem_req=1 with stable addr/we/wdata/be.
  - Counter increments each WAIT cycle.
  - I_mem_ack=1: capture I_mem_rdata, go to RESP, O_mem_req=0 next cycle.
  - Counter reaching TIMEOUT_CYCLES with no ack: go IDLE with O_fault=1, cause 10.
  - Ack in the expiry cycle wins.
  - Earliest ack is the first WAIT cycle, so minimum latency is request accept → O_done 3 cycles (accept, WAIT, RESP).
- RESP: O_done=1 for one cycle, O_rdata updated, then return to IDLE with O_ready=1.
  - O_rdata holds its value until the next O_done.
  - A new I_valid is not accepted during RESP.
- Store lanes (off = addr[1:0]):
  - SB: wdata={4{b[7:0]}}, be=0001<<off.
  - SH: wdata={2{h[15:0]}}, be=0011<<off.
  - SW: wdata=wdata, be=1111.
- Load extract:
  - Byte = rdata[8*off+:8].
  - Half = rdata[16*off[1]+:16].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word.
  - Stores return O_rdata=0.
- I_mem_ack outside WAIT is ignored.
- Counter clears on entry to WAIT.

Test Plan:
- LW addr 0x100, ack after 2 WAIT cycles with rdata 0xDEADBEEF → O_mem_addr 0x100, be 1111, we 0; O_done with O_rdata 0xDEADBEEF, 4 cycles after accept.
- LB addr 0x203 rdata 0x80112233 → O_mem_addr 0x200, O_rdata 0xFFFFFF80; same with LBU → 0x00000080; LHU addr 0x202 → 0x00008011.
- SB addr 0x7 wdata 0x123456AB → O_mem_addr 0x4, be 1000, wdata 0xABABABAB, we 1; SH addr 0x6 → be 1100, wdata 0x56AB56AB; O_rdata 0.
- LW addr 0x102 → O_fault next cycle, cause 01, O_mem_req never asserted; I_load=I_store=1 → cause 11.
- TIMEOUT_CYCLES=4, LW with no ack → O_mem_req high exactly 4 cycles, then O_fault cause 10, O_ready=1. Repeat with ack on 4th cycle → O_done, no fault.
- Assert I_rst_n=0 during WAIT → O_mem_req, O_done, O_fault drop immediately, O_ready=1; a subsequent LW completes normally.

Source files
------------

// File: rtl/lsu_mem_stage.sv
// lsu_mem_stage: load/store unit fed by the integer ALU.
// A request issues one word-bus transaction. The unit steers store lanes and
// generates byte enables. It extracts and extends load data, or reports a
// misaligned, illegal or bus-timeout fault.
module lsu_mem_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        I_clk,
  input  logic        I_rst_n,
  input  logic        I_valid,
  input  logic        I_load,
  input  logic        I_store,
  input  logic [2:0]  I_funct3,
  input  logic [31:0] I_addr,
  input  logic [31:0] I_wdata,
  output logic        O_ready,
  output logic        O_done,
  output logic [31:0] O_rdata,
  output logic        O_fault,
  output logic [1:0]  O_fault_cause,
  output logic        O_mem_req,
  output logic        O_mem_we,
  output logic [31:0] O_mem_addr,
  output logic [31:0] O_mem_wdata,
  output logic [3:0]  O_mem_be,
  input  logic        I_mem_ack,
  input  logic [31:0] I_mem_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } state_t;

  localparam logic [1:0] CAUSE_NONE     = 2'b00;
  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b10;
  localparam logic [1:0] CAUSE_ILLEGAL  = 2'b11;

  // TIMEOUT_CYCLES is limited to 1..255, so 8 bits hold the WAIT cycle count.
  localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYCLES);

  // Classify a request. The illegal-op check has priority over misalignment.
  function automatic logic [1:0] req_check(input logic       ld,
                                           input logic       st,
                                           input logic [2:0] f3,
                                           input logic [1:0] off);
    logic [1:0] cause;
    cause = CAUSE_NONE;
    if (ld == st) begin
      cause = CAUSE_ILLEGAL;
    end else if (ld) begin
      case (f3)
        3'b000, 3'b100: cause = CAUSE_NONE;
        3'b001, 3'b101: cause = off[0] ? CAUSE_MISALIGN : CAUSE_NONE;
        3'b010:         cause = (off != 2'b00) ? CAUSE_MISALIGN : CAUSE_NONE;
        default:        cause = CAUSE_ILLEGAL;
      endcase
    end else begin
      case (f3)
        3'b000:  cause = CAUSE_NONE;
        3'b001:  cause = off[0] ? CAUSE_MISALIGN : CAUSE_NONE;
        3'b010:  cause = (off != 2'b00) ? CAUSE_MISALIGN : CAUSE_NONE;
        default: cause = CAUSE_ILLEGAL;
      endcase
    end
    return cause;
  endfunction

  // Replicate the store operand across every lane the access could land in.
  function automatic logic [31:0] store_lanes(input logic [2:0]  f3,
                                              input logic [31:0] wd);
    logic [31:0] lanes;
    case (f3[1:0])
      2'b00:   lanes = {4{wd[7:0]}};
      2'b01:   lanes = {2{wd[15:0]}};
      default: lanes = wd;
    endcase
    return lanes;
  endfunction

  // Byte enables: loads always read the full word.
  function automatic logic [3:0] store_be(input logic       st,
                                          input logic [2:0] f3,
                                          input logic [1:0] off);
    logic [3:0] be;
    if (!st) begin
      be = 4'b1111;
    end else begin
      case (f3[1:0])
        2'b00:   be = 4'b0001 << off;
        2'b01:   be = 4'b0011 << off;
        default: be = 4'b1111;
      endcase
    end
    return be;
  endfunction

  // Pick the addressed byte/half out of the bus word and extend it.
  // A store completes with a zero result.
  function automatic logic [31:0] load_extract(input logic        ld,
                                               input logic [2:0]  f3,
                                               input logic [1:0]  off,
                                               input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    b = rd[{off, 3'b000} +: 8];
    h = rd[{off[1], 4'b0000} +: 16];
    if (!ld) begin
      res = 32'h0000_0000;
    end else begin
      case (f3)
        3'b000:  res = {{24{b[7]}}, b};
        3'b001:  res = {{16{h[15]}}, h};
        3'b100:  res = {24'h00_0000, b};
        3'b101:  res = {16'h0000, h};
        default: res = rd;
      endcase
    end
    return res;
  endfunction

  state_t      state_r;
  state_t      state_s;
  logic [7:0]  cnt_r;
  logic        ready_r;
  logic        done_r;
  logic [31:0] rdata_r;
  logic        fault_r;
  logic [1:0]  cause_r;
  logic        req_r;
  logic        we_r;
  logic [31:0] maddr_r;
  logic [31:0] mwdata_r;
  logic [3:0]  be_r;
  logic        req_load_r;
  logic [2:0]  req_f3_r;
  logic [1:0]  req_off_r;

  logic [1:0]  chk_cause_s;
  logic        accept_s;
  logic        reject_s;
  logic        ack_take_s;
  logic        timeout_s;

  assign chk_cause_s = req_check(I_load, I_store, I_funct3, I_addr[1:0]);

  // Next-state logic and the one-cycle event strobes that drive the registers.
  always_comb begin
    state_s    = state_r;
    accept_s   = 1'b0;
    reject_s   = 1'b0;
    ack_take_s = 1'b0;
    timeout_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (I_valid) begin
          if (chk_cause_s != CAUSE_NONE) begin
            reject_s = 1'b1;
            state_s  = ST_IDLE;
          end else begin
            accept_s = 1'b1;
            state_s  = ST_WAIT;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        // An ack in the expiry cycle still completes the request.
        if (I_mem_ack) begin
          ack_take_s = 1'b1;
          state_s    = ST_RESP;
        end else if ((cnt_r + 8'd1) >= TIMEOUT_LIM) begin
          timeout_s = 1'b1;
          state_s   = ST_IDLE;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_RESP: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Registered handshake flags that track the state being entered.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      ready_r <= 1'b1;
      req_r   <= 1'b0;
    end else begin
      ready_r <= (state_s == ST_IDLE);
      req_r   <= (state_s == ST_WAIT);
    end
  end

  // WAIT-cycle counter: restarts at zero on every accepted request.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      cnt_r <= 8'd0;
    end else if (accept_s) begin
      cnt_r <= 8'd0;
    end else if ((state_r == ST_WAIT) && !I_mem_ack) begin
      cnt_r <= cnt_r + 8'd1;
    end
  end

  // Latch the bus-side view of an accepted request; held stable through WAIT.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      we_r     <= 1'b0;
      maddr_r  <= 32'h0000_0000;
      mwdata_r <= 32'h0000_0000;
      be_r     <= 4'b0000;
    end else if (accept_s) begin
      we_r     <= I_store;
      maddr_r  <= {I_addr[31:2], 2'b00};
      mwdata_r <= store_lanes(I_funct3, I_wdata);
      be_r     <= store_be(I_store, I_funct3, I_addr[1:0]);
    end
  end

  // Keep what the response path needs to shape the returned word.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      req_load_r <= 1'b0;
      req_f3_r   <= 3'b000;
      req_off_r  <= 2'b00;
    end else if (accept_s) begin
      req_load_r <= I_load;
      req_f3_r   <= I_funct3;
      req_off_r  <= I_addr[1:0];
    end
  end

  // Completion pulse and result; the result holds until the next completion.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      done_r  <= 1'b0;
      rdata_r <= 32'h0000_0000;
    end else begin
      done_r <= ack_take_s;
      if (ack_take_s) begin
        rdata_r <= load_extract(req_load_r, req_f3_r, req_off_r, I_mem_rdata);
      end
    end
  end

  // Fault pulse; the cause holds until the next fault.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      fault_r <= 1'b0;
      cause_r <= CAUSE_NONE;
    end else begin
      fault_r <= reject_s | timeout_s;
      if (reject_s) begin
        cause_r <= chk_cause_s;
      end else if (timeout_s) begin
        cause_r <= CAUSE_TIMEOUT;
      end
    end
  end

  assign O_ready       = ready_r;
  assign O_done        = done_r;
  assign O_rdata       = rdata_r;
  assign O_fault       = fault_r;
  assign O_fault_cause = cause_r;
  assign O_mem_req     = req_r;
  assign O_mem_we      = we_r;
  assign O_mem_addr    = maddr_r;
  assign O_mem_wdata   = mwdata_r;
  assign O_mem_be      = be_r;

endmodule
